feature_window_streamer: RTL and testbench

Self-sequencing successor of the image RAM/line-buffer front end for the LeNet accelerator. Holds a dual-port image/weight RAM, generates its own read addresses for a configurable job, and streams either weights (preload) or K wavefront-skewed feature-map rows into the systolic array. Every stream carries true per-row valid flags and a job-level busy/done handshake. Sits between the DMA/write port and the PE array.

---
 rtl/feature_window_streamer.sv | 193 +++++++++++++++++++
 tb/tb_feature_window_streamer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/feature_window_streamer.sv
// Self-sequencing RAM reader that streams weights or K skewed line-buffer rows into the PE array.
// Optional FWS_PERF_CNT_EN builds a saturating valid-beat counter on perf_cnt.
module feature_window_streamer #(
    parameter int DATA_WIDTH      = 8,
    parameter int ADDR_WIDTH      = 11,
    parameter int MAX_WIDTH       = 32,
    parameter int K               = 5,
    parameter int WAVEFRONT_DELAY = 4,
    parameter int WW              = $clog2(MAX_WIDTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    start,
    input  logic                    wori,
    input  logic [ADDR_WIDTH-1:0]   base_addr,
    input  logic [WW-1:0]           fm_width,
    input  logic [ADDR_WIDTH:0]     job_len,
    output logic                    busy,
    output logic                    done,
    output logic [DATA_WIDTH-1:0]   weight_out,
    output logic                    weight_valid,
    output logic [K*DATA_WIDTH-1:0] row_out,
    output logic [K-1:0]            row_valid,
    output logic [15:0]             perf_cnt
);
    // Line buffer is one tapped delay line; assumes K >= 2.
    localparam int LB_LEN  = (K - 1) * MAX_WIDTH;
    localparam int TW      = (LB_LEN > 1) ? $clog2(LB_LEN) : 1;
    localparam int W_DRAIN = 2;
    localparam int I_DRAIN = 2 + (K - 1) * WAVEFRONT_DELAY;
    localparam int CW      = $clog2(I_DRAIN + 1);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t                  state, nxt;
    logic                    accept, rd_vld, illegal;
    logic                    wori_q;
    logic [ADDR_WIDTH-1:0]   base_q, rd_addr;
    logic [WW-1:0]           fw_q;
    logic [ADDR_WIDTH:0]     n_q, idx;
    logic [CW-1:0]           drain_cnt;

    logic [DATA_WIDTH-1:0]   mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0]   ram_q, smp;
    logic                    ram_vld, smp_vld;

    logic [LB_LEN-1:0]                 lb_v;
    logic [LB_LEN-1:0][DATA_WIDTH-1:0] lb_d;

    assign illegal = (job_len == '0) || (fm_width == '0) || (int'(fm_width) > MAX_WIDTH);
    assign rd_addr = base_q + idx[ADDR_WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt    = state;
        accept = 1'b0;
        rd_vld = 1'b0;
        case (state)
            S_IDLE:  if (start) begin
                         accept = 1'b1;
                         nxt    = illegal ? S_DONE : S_READ;
                     end
            S_READ:  begin
                         rd_vld = 1'b1;
                         if (idx == n_q - 1'b1) nxt = S_DRAIN;
                     end
            S_DRAIN: if (drain_cnt == '0) nxt = S_DONE;
            S_DONE:  nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wori_q    <= 1'b0;
            base_q    <= '0;
            fw_q      <= '0;
            n_q       <= '0;
            idx       <= '0;
            drain_cnt <= '0;
        end else begin
            if (accept) begin
                wori_q <= wori;
                base_q <= base_addr;
                fw_q   <= fm_width;
                n_q    <= job_len;
                idx    <= '0;
            end
            if (state == S_READ) begin
                idx <= idx + 1'b1;
                if (nxt == S_DRAIN)
                    drain_cnt <= wori_q ? CW'(W_DRAIN - 1) : CW'(I_DRAIN - 1);
            end
            if (state == S_DRAIN) drain_cnt <= drain_cnt - 1'b1;
        end
    end

    // Nonblocking read of mem gives old data on a same-address write.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        ram_q <= mem[rd_addr];
        smp   <= ram_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_vld <= 1'b0;
            smp_vld <= 1'b0;
        end else begin
            ram_vld <= rd_vld;
            smp_vld <= ram_vld;
        end
    end

    assign weight_valid = smp_vld & wori_q;
    assign weight_out   = weight_valid ? smp : '0;

    // Valid bits are wiped on every accepted start so leftovers from the last job stay invisible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lb_v <= '0;
        else if (accept) lb_v <= '0;
        else begin
            lb_v[0] <= smp_vld & ~wori_q;
            for (int k = 1; k < LB_LEN; k++) lb_v[k] <= lb_v[k-1];
        end
    end

    always_ff @(posedge clk) begin
        lb_d[0] <= smp;
        for (int k = 1; k < LB_LEN; k++) lb_d[k] <= lb_d[k-1];
    end

    for (genvar j = 0; j < K; j++) begin : g_row
        localparam int D = j * WAVEFRONT_DELAY;
        logic                  pre_v;
        logic [DATA_WIDTH-1:0] pre_d;

        if (j == 0) begin : g_r0
            assign pre_v = smp_vld & ~wori_q;
            assign pre_d = smp;
        end else begin : g_rn
            // lb entry t holds the sample delayed by t+1 cycles.
            logic [TW-1:0] tap;
            assign tap   = TW'(j * int'(fw_q) - 1);
            assign pre_v = smp_vld & ~wori_q & lb_v[tap];
            assign pre_d = lb_d[tap];
        end

        if (D == 0) begin : g_noskew
            assign row_valid[j]                         = pre_v;
            assign row_out[j*DATA_WIDTH +: DATA_WIDTH] = pre_v ? pre_d : '0;
        end else begin : g_skew
            logic [D-1:0]                 sk_v;
            logic [D-1:0][DATA_WIDTH-1:0] sk_d;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) sk_v <= '0;
                else begin
                    sk_v[0] <= pre_v;
                    for (int k = 1; k < D; k++) sk_v[k] <= sk_v[k-1];
                end
            end
            always_ff @(posedge clk) begin
                sk_d[0] <= pre_d;
                for (int k = 1; k < D; k++) sk_d[k] <= sk_d[k-1];
            end
            assign row_valid[j]                         = sk_v[D-1];
            assign row_out[j*DATA_WIDTH +: DATA_WIDTH] = sk_v[D-1] ? sk_d[D-1] : '0;
        end
    end

`ifdef FWS_PERF_CNT_EN
    logic [15:0] perf_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) perf_q <= '0;
        else if (accept) perf_q <= '0;
        else if (((|row_valid) || weight_valid) && (perf_q != 16'hFFFF)) perf_q <= perf_q + 1'b1;
    end
    assign perf_cnt = perf_q;
`else
    assign perf_cnt = '0;
`endif

endmodule

// File: tb/tb_feature_window_streamer.sv
// Directed bench for feature_window_streamer: weight/inference streams, wrap, illegal jobs,
// collision, back-to-back jobs, stale line buffer and mid-job reset.
module tb_feature_window_streamer;
    localparam int DW = 8, AW = 11, MW = 32, K = 5, WD = 4, WW = 6;

    logic              clk = 1'b0, rst_n = 1'b0;
    logic              wr_en = 1'b0, start = 1'b0, wori = 1'b0;
    logic [AW-1:0]     wr_addr = '0, base_addr = '0;
    logic [DW-1:0]     wr_data = '0;
    logic [WW-1:0]     fm_width = '0;
    logic [AW:0]       job_len = '0;
    logic              busy, done, weight_valid;
    logic [DW-1:0]     weight_out;
    logic [K*DW-1:0]   row_out;
    logic [K-1:0]      row_valid;
    logic [15:0]       perf_cnt;

    int n_chk = 0, n_fail = 0;

    logic [55:0] obs, expv;
    logic        eb, ed, ewv;
    logic [7:0]  ewo;
    logic [4:0]  erv;
    logic [39:0] ero;
    logic [15:0] exp_perf;

    assign obs = {busy, done, weight_valid, weight_out, row_valid, row_out};

    feature_window_streamer dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .wori(wori), .base_addr(base_addr), .fm_width(fm_width),
        .job_len(job_len), .busy(busy), .done(done), .weight_out(weight_out),
        .weight_valid(weight_valid), .row_out(row_out), .row_valid(row_valid),
        .perf_cnt(perf_cnt)
    );

    always #5 clk = ~clk;

    task automatic ram_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk); wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(posedge clk); #1 wr_en = 1'b0;
    endtask

    // Returns at the start of cycle 0 of the new job.
    task automatic start_job(input logic w, input logic [AW-1:0] b, input logic [WW-1:0] fw,
                             input logic [AW:0] n);
        @(negedge clk); start = 1'b1; wori = w; base_addr = b; fm_width = fw; job_len = n;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic clr_exp();
        eb = 0; ed = 0; ewv = 0; ewo = '0; erv = '0; ero = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++;
        if (obs !== 56'h0 || perf_cnt !== 16'h0) begin
            n_fail++; $display("FAIL reset_hold got %h/%h exp 0", obs, perf_cnt);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_chk++;
        if (obs !== 56'h0 || perf_cnt !== 16'h0) begin
            n_fail++; $display("FAIL reset_release got %h/%h exp 0", obs, perf_cnt);
        end
    endtask

    task automatic test_weight();
        for (int i = 0; i < 5; i++) ram_wr(AW'(100 + i), DW'(i + 1));
        start_job(1'b1, 11'd100, 6'd8, 12'd5);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            // A start while busy must not disturb the running job.
            if (c == 3) begin start = 1'b1; wori = 1'b0; base_addr = '0; job_len = 12'd9; end
            if (c == 4) start = 1'b0;
            clr_exp();
            eb = (c <= 7); ed = (c == 7); ewv = (c >= 2 && c <= 6);
            ewo = ewv ? 8'(c - 1) : 8'h0;
            expv = {eb, ed, ewv, ewo, erv, ero};
            n_chk++;
            if (obs !== expv) begin
                n_fail++; $display("FAIL weight c=%0d got %h exp %h", c, obs, expv);
            end
        end
`ifdef FWS_PERF_CNT_EN
        exp_perf = 16'd5;
`else
        exp_perf = 16'd0;
`endif
        n_chk++;
        if (perf_cnt !== exp_perf) begin
            n_fail++; $display("FAIL perf_cnt got %0d exp %0d", perf_cnt, exp_perf);
        end
    endtask

    task automatic test_wrap();
        ram_wr(11'd2046, 8'hA1); ram_wr(11'd2047, 8'hA2);
        ram_wr(11'd0, 8'hA3);    ram_wr(11'd1, 8'hA4);
        start_job(1'b1, 11'd2046, 6'd8, 12'd4);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            clr_exp();
            eb = (c <= 6); ed = (c == 6); ewv = (c >= 2 && c <= 5);
            ewo = ewv ? 8'(8'hA1 + c - 2) : 8'h0;
            expv = {eb, ed, ewv, ewo, erv, ero};
            n_chk++;
            if (obs !== expv) begin
                n_fail++; $display("FAIL wrap c=%0d got %h exp %h", c, obs, expv);
            end
        end
    endtask

    task automatic test_collision();
        for (int i = 0; i < 3; i++) ram_wr(AW'(200 + i), DW'(10 + i));
        start_job(1'b1, 11'd200, 6'd8, 12'd3);
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            // Write lands on the same edge that reads address 201.
            if (c == 1) begin wr_en = 1'b1; wr_addr = 11'd201; wr_data = 8'd99; end
            if (c == 2) wr_en = 1'b0;
            clr_exp();
            eb = (c <= 5); ed = (c == 5); ewv = (c >= 2 && c <= 4);
            ewo = ewv ? 8'(10 + c - 2) : 8'h0;
            expv = {eb, ed, ewv, ewo, erv, ero};
            n_chk++;
            if (obs !== expv) begin
                n_fail++; $display("FAIL collision c=%0d got %h exp %h", c, obs, expv);
            end
        end
        start_job(1'b1, 11'd201, 6'd8, 12'd1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            clr_exp();
            eb = (c <= 3); ed = (c == 3); ewv = (c == 2); ewo = ewv ? 8'd99 : 8'h0;
            expv = {eb, ed, ewv, ewo, erv, ero};
            n_chk++;
            if (obs !== expv) begin
                n_fail++; $display("FAIL collision_wr c=%0d got %h exp %h", c, obs, expv);
            end
        end
    endtask

    task automatic test_illegal();
        logic [WW-1:0] fws [3];
        logic [AW:0]   ns  [3];
        fws = '{6'd0, 6'd8, 6'd33};
        ns  = '{12'd5, 12'd0, 12'd5};
        for (int t = 0; t < 3; t++) begin
            start_job(t[0], 11'd100, fws[t], ns[t]);
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                clr_exp();
                eb = (c == 0); ed = (c == 0);
                expv = {eb, ed, ewv, ewo, erv, ero};
                n_chk++;
                if (obs !== expv) begin
                    n_fail++; $display("FAIL illegal t=%0d c=%0d got %h exp %h", t, c, obs, expv);
                end
            end
        end
    endtask

    task automatic test_inference();
        int s;
        for (int i = 0; i < 1024; i++) ram_wr(AW'(i), DW'(i % 256));
        start_job(1'b0, 11'd0, 6'd32, 12'd1024);
        for (int c = 0; c < 1046; c++) begin
            @(negedge clk);
            clr_exp();
            eb = (c <= 1042); ed = (c == 1042);
            for (int j = 0; j < K; j++) begin
                s = c - 2 - j * (32 + WD);
                if (s >= 0 && s + j * 32 < 1024) begin
                    erv[j] = 1'b1;
                    ero[j*8 +: 8] = 8'(s % 256);
                end
            end
            expv = {eb, ed, ewv, ewo, erv, ero};
            n_chk++;
            if (obs !== expv) begin
                n_fail++;
                if (n_fail < 20) $display("FAIL inference c=%0d got %h exp %h", c, obs, expv);
            end
            if (c == 145 || c == 146) begin
                n_chk++;
                if (row_valid[4] !== (c == 146) || row_out[39:32] !== 8'h0) begin
                    n_fail++; $display("FAIL row4_first c=%0d got %b/%h", c, row_valid[4], row_out[39:32]);
                end
            end
        end
    endtask

    // Short job after a long one: rows 1..4 must never light up from old line-buffer data.
    task automatic test_stale_rows();
        start_job(1'b0, 11'd0, 6'd4, 12'd3);
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            clr_exp();
            eb = (c <= 21); ed = (c == 21);
            erv[0] = (c >= 2 && c <= 4);
            ero[7:0] = erv[0] ? 8'(c - 2) : 8'h0;
            expv = {eb, ed, ewv, ewo, erv, ero};
            n_chk++;
            if (obs !== expv) begin
                n_fail++; $display("FAIL stale c=%0d got %h exp %h", c, obs, expv);
            end
        end
    endtask

    task automatic test_back_to_back();
        int d;
        start_job(1'b1, 11'd100, 6'd8, 12'd2);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c == 5) begin start = 1'b1; wori = 1'b1; base_addr = 11'd102; job_len = 12'd1; end
            if (c == 6) start = 1'b0;
            clr_exp();
            if (c <= 4) begin
                eb = 1; ed = (c == 4); ewv = (c == 2 || c == 3);
                ewo = ewv ? 8'(100 + c - 2) : 8'h0;
            end else if (c >= 6) begin
                d = c - 6;
                eb = (d <= 3); ed = (d == 3); ewv = (d == 2); ewo = ewv ? 8'd102 : 8'h0;
            end
            expv = {eb, ed, ewv, ewo, erv, ero};
            n_chk++;
            if (obs !== expv) begin
                n_fail++; $display("FAIL b2b c=%0d got %h exp %h", c, obs, expv);
            end
        end
    endtask

    task automatic test_reset_mid_job();
        start_job(1'b0, 11'd0, 6'd32, 12'd1024);
        repeat (50) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_chk++;
        if (obs !== 56'h0 || perf_cnt !== 16'h0) begin
            n_fail++; $display("FAIL reset_mid got %h/%h exp 0", obs, perf_cnt);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n_chk++;
            if (obs !== 56'h0) begin
                n_fail++; $display("FAIL after_abort c=%0d got %h exp 0", c, obs);
            end
        end
    endtask

    initial begin
        test_reset();
        test_weight();
        test_wrap();
        test_collision();
        test_illegal();
        test_inference();
        test_stale_rows();
        test_back_to_back();
        test_reset_mid_job();
        test_stale_rows();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
